// File: rtl/entry_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | entry_pkg : shared types/constants for the operand entry front end |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
package entry_pkg;

  localparam int OPERAND_W = 4;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_OP   = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | btn_debounce : synchronise, debounce, emit 1-cycle press pulse     |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
module btn_debounce
  import entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          stable_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised level disagrees with the
  // accepted level, so any agreeing sample restarts the qualification window.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      sync1_q       <= raw;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
    end
  end

  assign pulse = stable_q & ~stable_prev_q;

endmodule
`default_nettype wire

// File: rtl/operand_entry.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | operand_entry : button-driven A / B / op entry for addSub4         |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
module operand_entry
  import entry_pkg::*;
#(
  parameter int W               = OPERAND_W,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] sw,
  input  logic         btn_enter_raw,
  input  logic         btn_clear_raw,
  output logic [W-1:0] av,
  output logic [W-1:0] bv,
  output logic         M,
  output logic         operands_valid,
  output logic [1:0]   phase
);

  logic         enter_pulse, clear_pulse;
  state_t       state_q;
  logic [W-1:0] av_q, bv_q;
  logic         m_q, valid_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk  (clk),
    .reset(reset),
    .raw  (btn_enter_raw),
    .pulse(enter_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk  (clk),
    .reset(reset),
    .raw  (btn_clear_raw),
    .pulse(clear_pulse)
  );

  // Clear is checked first so it beats an enter pulse in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_A;
      av_q    <= '0;
      bv_q    <= '0;
      m_q     <= 1'b0;
      valid_q <= 1'b0;
    end else if (clear_pulse) begin
      state_q <= S_A;
      av_q    <= '0;
      bv_q    <= '0;
      m_q     <= 1'b0;
      valid_q <= 1'b0;
    end else if (enter_pulse) begin
      case (state_q)
        S_A: begin
          av_q    <= sw;
          state_q <= S_B;
        end
        S_B: begin
          bv_q    <= sw;
          state_q <= S_OP;
        end
        S_OP: begin
          m_q     <= sw[0];
          valid_q <= 1'b1;
          state_q <= S_DONE;
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= S_A;
        end
      endcase
    end
  end

  assign av             = av_q;
  assign bv             = bv_q;
  assign M              = m_q;
  assign operands_valid = valid_q;
  assign phase          = state_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_entry.sv
`default_nettype none
// Bench for operand_entry: window-based debounce/entry model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_operand_entry;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] sw = 4'h0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] av, bv;
  logic       M, operands_valid;
  logic [1:0] phase;

  int n_tests = 0;
  int n_fail  = 0;

  operand_entry #(.W(4), .DEBOUNCE_CYCLES(DC)) dut (
    .clk           (clk),
    .reset         (reset),
    .sw            (sw),
    .btn_enter_raw (en),
    .btn_clear_raw (clr),
    .av            (av),
    .bv            (bv),
    .M             (M),
    .operands_valid(operands_valid),
    .phase         (phase)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A button level is accepted once the last DC synchronised samples (raw
  // samples two clocks old) all disagree with the accepted level; a rising
  // acceptance acts on the entry sequence one clock later.
  bit         eq[$], cq[$];
  bit         e_st, c_st, e_pend, c_pend;
  int         m_state;
  logic [3:0] m_a, m_b;
  bit         m_m, m_v;

  function automatic bit flip_due(input bit q[$], input bit st);
    int sz = q.size();
    for (int k = 2; k <= DC + 1; k++)
      if (q[sz-k] == st) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      eq.delete();
      cq.delete();
      for (int i = 0; i < DC + 2; i++) begin
        eq.push_back(1'b0);
        cq.push_back(1'b0);
      end
      e_st = 0; c_st = 0; e_pend = 0; c_pend = 0;
      m_state = 0; m_a = 0; m_b = 0; m_m = 0; m_v = 0;
    end else begin
      if (c_pend) begin
        m_state = 0; m_a = 0; m_b = 0; m_m = 0; m_v = 0;
      end else if (e_pend) begin
        if (m_state == 0) m_a = sw;
        else if (m_state == 1) m_b = sw;
        else if (m_state == 2) begin m_m = sw[0]; m_v = 1; end
        else m_v = 0;
        m_state = (m_state + 1) % 4;
      end
      e_pend = 0;
      c_pend = 0;
      if (flip_due(eq, e_st)) begin e_st = !e_st; e_pend = e_st; end
      if (flip_due(cq, c_st)) begin c_st = !c_st; c_pend = c_st; end
      eq.push_back(en);
      cq.push_back(clr);
      if (eq.size() > DC + 2) void'(eq.pop_front());
      if (cq.size() > DC + 2) void'(cq.pop_front());
    end
  end

  always @(negedge clk) begin
    n_tests++;
    if ({av, bv, M, operands_valid, phase} !== {m_a, m_b, m_m, m_v, 2'(m_state)}) begin
      n_fail++;
      $display("FAIL model t=%0t: got av=%h bv=%h M=%b v=%b ph=%0d, expected av=%h bv=%h M=%b v=%b ph=%0d",
               $time, av, bv, M, operands_valid, phase, m_a, m_b, m_m, m_v, m_state);
    end
  end

  // ---------------- directed checks ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] v);
    sw = v; en = 1'b1; cyc(8);
    en = 1'b0; cyc(8);
  endtask

  function automatic int addsub(input logic [3:0] a, input logic [3:0] b, input logic m);
    logic [3:0] r;
    r = m ? (a - b) : (a + b);
    return int'(r);
  endfunction

  initial begin
    int k;
    reset = 1'b0;
    cyc(3);
    chk("reset_av", av, 0);
    chk("reset_phase", phase, 0);
    chk("reset_valid", operands_valid, 0);
    @(negedge clk); #2 reset = 1'b1;
    cyc(10);
    chk("idle_phase", phase, 0);
    chk("idle_M", M, 0);

    press(4'h5); press(4'h3); press(4'h1);
    chk("entry_av", av, 5);
    chk("entry_bv", bv, 3);
    chk("entry_M", M, 1);
    chk("entry_valid", operands_valid, 1);
    chk("entry_phase", phase, 3);
    chk("entry_addsub", addsub(av, bv, M), 2);

    press(4'hE);
    chk("wrap_valid", operands_valid, 0);
    chk("wrap_phase", phase, 0);
    chk("wrap_av", av, 5);
    chk("wrap_bv", bv, 3);

    sw = 4'h9;
    en = 1; cyc(1); en = 0; cyc(1); en = 1; cyc(1); en = 0; cyc(1);
    en = 1;
    k = 0;
    while (phase == 2'd0 && k < 12) begin cyc(1); k++; end
    n_tests++;
    if (k < 5 || k > 8) begin
      n_fail++;
      $display("FAIL bounce_latency: got %0d cycles, expected 5..8", k);
    end
    if (k < 10) cyc(10 - k);
    en = 0; cyc(8);
    chk("bounce_phase", phase, 1);
    chk("bounce_av", av, 9);

    en = 1; clr = 1; cyc(8);
    en = 0; clr = 0; cyc(8);
    chk("clr_phase", phase, 0);
    chk("clr_av", av, 0);
    chk("clr_valid", operands_valid, 0);

    sw = 4'h4; en = 1; cyc(50);
    chk("hold_phase", phase, 1);
    en = 0; cyc(8);
    press(4'h6);
    chk("hold2_phase", phase, 2);
    chk("hold2_av", av, 4);
    chk("hold2_bv", bv, 6);

    en = 1; cyc(2);
    @(negedge clk); #2 reset = 1'b0;
    cyc(2);
    chk("rst_mid_phase", phase, 0);
    chk("rst_mid_bv", bv, 0);
    sw = 4'hA;
    @(negedge clk); #2 reset = 1'b1;
    k = 0;
    while (phase == 2'd0 && k < 15) begin cyc(1); k++; end
    chk("rst_held_phase", phase, 1);
    chk("rst_held_av", av, 10);
    en = 0; cyc(8);

    press(4'h7); press(4'h0);
    chk("fresh_bv", bv, 7);
    chk("fresh_M", M, 0);
    chk("fresh_valid", operands_valid, 1);
    chk("fresh_addsub", addsub(av, bv, M), 1);
    press(4'hF); press(4'h2);
    chk("over_av", av, 2);
    chk("over_phase", phase, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
